// File: rtl/counter_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed
// common-anode 3-digit seven-segment display.
module counter_bcd_display #(
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [7:0]    r_last;
    logic [19:0]   r_shift;
    logic [2:0]    r_iter;
    logic [11:0]   r_bcd;
    logic          r_valid;
    logic          r_busy;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg;
    logic [2:0]    r_an;

    logic [19:0]   w_adj;
    logic [19:0]   w_next;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [2:0]    w_an;
    logic [6:0]    w_seg;

    // Double-dabble step: correct every BCD nibble >= 5, then shift left.
    always_comb begin
        w_adj = r_shift;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5)
                w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
        end
        w_next = w_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= '0;
            r_shift <= '0;
            r_iter  <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (value != r_last) begin
                        r_shift <= {12'd0, value};
                        r_last  <= value;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_shift <= w_next;
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd   <= r_shift[19:8];
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit select for the current scan slot; only committed bcd is shown.
    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        w_an    = 3'b110;
        case (r_idx)
            2'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = (BLANK_LEADING != 0) && (r_bcd[11:4] == '0);
                w_an    = 3'b101;
            end
            2'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = (BLANK_LEADING != 0) && (r_bcd[11:8] == '0);
                w_an    = 3'b011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (w_blank)
            w_seg = 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= 7'b1000000;
            r_an      <= 3'b110;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
            if (r_refresh == CW'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;
    assign busy      = r_busy;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: tb/tb_counter_bcd_display.sv
// Directed bench for counter_bcd_display: two instances (blanking on/off)
// checked every cycle against an arithmetic model, plus literal spot checks.
module tb_counter_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  value = 8'd0;

    logic [11:0] bcd_b, bcd_n;
    logic        valid_b, valid_n, busy_b, busy_n;
    logic [6:0]  seg_b, seg_n;
    logic [2:0]  an_b, an_n;

    int n_vec = 0;
    int n_err = 0;
    int vcnt  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    counter_bcd_display #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut_b (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_b), .bcd_valid(valid_b),
        .busy(busy_b), .seg(seg_b), .an(an_b)
    );

    counter_bcd_display #(.REFRESH_DIV(5), .BLANK_LEADING(0)) dut_n (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_n), .bcd_valid(valid_n),
        .busy(busy_n), .seg(seg_n), .an(an_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int div_of(input int n);
        return (n == 0) ? 4 : 5;
    endfunction

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] shown(input int n, input int v, input int idx);
        int d;
        if (idx == 0)      d = v % 10;
        else if (idx == 1) d = (v / 10) % 10;
        else               d = v / 100;
        if (n == 0 && ((idx == 2 && v < 100) || (idx == 1 && v < 10)))
            return 7'b1111111;
        return pattern(d);
    endfunction

    function automatic logic [2:0] anode(input int idx);
        return (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    int         m_last [2];
    int         m_cnt  [2];
    int         m_bcdv [2];
    int         m_ref  [2];
    int         m_idx  [2];
    logic       m_valid[2];
    logic [6:0] m_seg  [2];
    logic [2:0] m_an   [2];

    // m_cnt: clocks until the pending result commits (0 = idle)
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                m_last[n]  <= 0;
                m_cnt[n]   <= 0;
                m_bcdv[n]  <= 0;
                m_valid[n] <= 1'b0;
                m_ref[n]   <= 0;
                m_idx[n]   <= 0;
                m_seg[n]   <= 7'b1000000;
                m_an[n]    <= 3'b110;
            end else begin
                m_seg[n] <= shown(n, m_bcdv[n], m_idx[n]);
                m_an[n]  <= anode(m_idx[n]);
                if (m_ref[n] == div_of(n) - 1) begin
                    m_ref[n] <= 0;
                    m_idx[n] <= (m_idx[n] + 1) % 3;
                end else begin
                    m_ref[n] <= m_ref[n] + 1;
                end
                m_valid[n] <= 1'b0;
                if (m_cnt[n] == 0) begin
                    if (int'(value) != m_last[n]) begin
                        m_last[n] <= int'(value);
                        m_cnt[n]  <= 9;
                    end
                end else begin
                    m_cnt[n] <= m_cnt[n] - 1;
                    if (m_cnt[n] == 1) begin
                        m_bcdv[n]  <= m_last[n];
                        m_valid[n] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("bcd_b",   32'(bcd_b),   32'(to_bcd(m_bcdv[0])));
            chk("valid_b", 32'(valid_b), 32'(m_valid[0]));
            chk("busy_b",  32'(busy_b),  32'(m_cnt[0] != 0));
            chk("seg_b",   32'(seg_b),   32'(m_seg[0]));
            chk("an_b",    32'(an_b),    32'(m_an[0]));
            chk("bcd_n",   32'(bcd_n),   32'(to_bcd(m_bcdv[1])));
            chk("valid_n", 32'(valid_n), 32'(m_valid[1]));
            chk("busy_n",  32'(busy_n),  32'(m_cnt[1] != 0));
            chk("seg_n",   32'(seg_n),   32'(m_seg[1]));
            chk("an_n",    32'(an_n),    32'(m_an[1]));
            if (valid_b) vcnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    int sel = 0;
    logic [2:0] an_s;
    logic [6:0] seg_s;
    always_comb begin
        an_s  = (sel == 0) ? an_b : an_n;
        seg_s = (sel == 0) ? seg_b : seg_n;
    end

    task automatic do_reset(input logic [7:0] v);
        rst = 1'b1;
        value = v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (valid_b) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic scan_check(input int s, input int div, input string tag,
                              input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        logic [2:0] prev;
        logic [2:0] ea [3];
        logic [6:0] es [3];
        bit found;
        sel = s;
        ea[0] = 3'b110; ea[1] = 3'b101; ea[2] = 3'b011;
        es[0] = s0;     es[1] = s1;     es[2] = s2;
        found = 1'b0;
        for (int i = 0; i < 3 * div + 2; i++) begin
            prev = an_s;
            @(negedge clk);
            if (an_s == 3'b110 && prev != 3'b110) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, " sync"}, 32'(found), 32'd1);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < div; c++) begin
                chk({tag, " an"},  32'(an_s),  32'(ea[k]));
                chk({tag, " seg"}, 32'(seg_s), 32'(es[k]));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n, n2, v0;
        @(posedge clk);
        started = 1'b1;

        // 1: reset state, then 255
        do_reset(8'd0);
        chk("t1 rst bcd",  32'(bcd_b),  32'h000);
        chk("t1 rst seg",  32'(seg_b),  32'b1000000);
        chk("t1 rst an",   32'(an_b),   32'b110);
        chk("t1 rst busy", 32'(busy_b), 32'd0);
        value = 8'd255;
        @(negedge clk);
        chk("t1 busy rise", 32'(busy_b), 32'd1);
        wait_valid(20, n);
        chk("t1 latency", 32'(n), 32'd9);
        chk("t1 bcd", 32'(bcd_b), 32'h255);
        @(negedge clk);
        chk("t1 busy fall",  32'(busy_b),  32'd0);
        chk("t1 single pulse", 32'(valid_b), 32'd0);

        // 2: 0 -> 1 -> 99 -> 100
        do_reset(8'd0);
        v0 = vcnt;
        repeat (12) @(negedge clk);
        chk("t2 bcd 0", 32'(bcd_b), 32'h000);
        value = 8'd1;   repeat (12) @(negedge clk);
        chk("t2 bcd 1", 32'(bcd_b), 32'h001);
        value = 8'd99;  repeat (12) @(negedge clk);
        chk("t2 bcd 99", 32'(bcd_b), 32'h099);
        value = 8'd100; repeat (12) @(negedge clk);
        chk("t2 bcd 100", 32'(bcd_b), 32'h100);
        chk("t2 pulses", 32'(vcnt - v0), 32'd3);

        // 3: change during conversion
        do_reset(8'd0);
        v0 = vcnt;
        value = 8'd10;
        repeat (3) @(negedge clk);
        value = 8'd200;
        wait_valid(20, n);
        chk("t3 first wait", 32'(n), 32'd7);
        chk("t3 first bcd", 32'(bcd_b), 32'h010);
        wait_valid(20, n2);
        chk("t3 second wait", 32'(n2), 32'd10);
        chk("t3 second bcd", 32'(bcd_b), 32'h200);
        repeat (12) @(negedge clk);
        chk("t3 pulses", 32'(vcnt - v0), 32'd2);

        // 4: scan of 123 with REFRESH_DIV=4
        do_reset(8'd0);
        value = 8'd123;
        repeat (12) @(negedge clk);
        scan_check(0, 4, "t4", 7'b0110000, 7'b0100100, 7'b1111001);

        // 5: value 7, blanking on and off
        do_reset(8'd0);
        value = 8'd7;
        repeat (12) @(negedge clk);
        scan_check(0, 4, "t5 blank", 7'b1111000, 7'b1111111, 7'b1111111);
        scan_check(1, 5, "t5 noblank", 7'b1111000, 7'b1000000, 7'b1000000);

        // 6: reset at 4th CONVERT cycle of 150
        do_reset(8'd0);
        value = 8'd150;
        repeat (4) @(negedge clk);
        chk("t6 busy before rst", 32'(busy_b), 32'd1);
        rst = 1'b1;
        value = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 seg", 32'(seg_b), 32'b1000000);
        chk("t6 an",  32'(an_b),  32'b110);
        chk("t6 busy", 32'(busy_b), 32'd0);
        v0 = vcnt;
        repeat (15) @(negedge clk);
        chk("t6 no pulse", 32'(vcnt - v0), 32'd0);
        chk("t6 bcd", 32'(bcd_b), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
